// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, optional parity, stop bit.
// All outputs are registered; the serial line is sampled only on edges where en is high.
module serial_frame_rx #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             perr,
    output logic             ferr,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             pflag_q, pflag_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;

    // Pulses default low so that disabled edges always terminate them after one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        pflag_d = pflag_q;
        q_d     = q_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = 1'b0;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (!d) begin
                        state_d = DATA;
                        cnt_d   = 5'd0;
                        pflag_d = 1'b0;
                    end
                end
                DATA: begin
                    shift_d = shift_q >> 1;
                    shift_d[WIDTH-1] = d;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = 5'd0;
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                PARITY: begin
                    pflag_d = (^shift_q) ^ d ^ PARITY_ODD;
                    state_d = STOP;
                end
                STOP: begin
                    if (d) begin
                        q_d     = shift_q;
                        valid_d = 1'b1;
                        perr_d  = PARITY_EN ? pflag_q : 1'b0;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        perr_d  = 1'b0;
                        state_d = BREAK;
                    end
                end
                BREAK: begin
                    // Wait for the line to return high so a held-low line is not seen as new starts.
                    if (d) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            shift_q <= '0;
            pflag_q <= 1'b0;
            q_q     <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            pflag_q <= pflag_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;
    assign perr  = perr_q;
    assign ferr  = ferr_q;
    assign busy  = busy_q;

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Serial-to-parallel frame receiver placed directly downstream of the D flip-flop stage. It consumes the registered serial bit stream (the flip-flop's q output) one bit per enabled clock. It detects start/data/parity/stop framing, assembles the data word LSB-first and presents it with a one-cycle valid pulse plus error flags. The block is fully synchronous to the same clk as the upstream flip-flop.

Parameters:
WIDTH, 8, number of data bits per frame (legal range 1..16)
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity expected; 1 = odd parity expected (ignored when PARITY_EN=0)

Ports:
clk  input  1  single clock; all state updates on the rising edge
clr  input  1  reset, synchronous, active-high
en  input  1  bit strobe; d is sampled only on edges where en=1
d  input  1  serial line from the upstream flip-flop q; idle level 1
q  output  WIDTH  last received data word, LSB = first data bit received
valid  output  1  one-cycle pulse: a frame with good stop bit completed
perr  output  1  parity error; meaningful only while valid=1
ferr  output  1  one-cycle pulse: stop bit sampled as 0
busy  output  1  1 whenever the state is not IDLE

Behaviour:
- Reset: clr=1 at a rising edge puts state in IDLE and sets q=0, valid=0, perr=0, ferr=0, busy=0, bit counter=0, shift register=0. clr has priority over every other input, including mid-frame. The partial frame is discarded.
- All outputs are registered. No combinational path exists from d or en to any output.
- Edges with en=0 hold all state. On such edges valid and ferr are forced to 0, so every pulse lasts exactly one clk cycle.
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE: on an en edge with d=0 (start bit), go to DATA with counter=0. An en edge with d=1 stays in IDLE.
- DATA: each en edge shifts d into the MSB of the shift register (right shift). After WIDTH bits the shift register holds the word LSB-first.
  - After the WIDTH-th bit, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: on the en edge, store the parity mismatch flag, then go to STOP.
  - Mismatch for even parity: XOR(data) ^ d != 0.
  - Mismatch for odd parity: XOR(data) ^ d != 1.
- STOP, en edge with d=1:
  - q <= shift register, valid <= 1, perr <= stored mismatch flag (0 when PARITY_EN=0), ferr <= 0.
  - Next state IDLE.
- STOP, en edge with d=0:
  - ferr <= 1, valid <= 0, perr <= 0, q unchanged.
  - Next state BREAK.
- BREAK: stay in BREAK until an en edge samples d=1, then go to IDLE. This prevents a held-low line from being read as repeated start bits.
- Latency: valid/ferr are high in the clk cycle immediately after the edge that samples the stop bit.
- Frame length: 1 + WIDTH + PARITY_EN + 1 enabled samples.
- Back-to-back frames: a start bit on the en edge immediately after a good stop bit is accepted, because state is already IDLE.
- q holds its value between frames and changes only on a good stop bit or on clr.
- busy is 1 from the cycle after the start bit is sampled until the cycle after the state returns to IDLE.

Test Plan:
- Reset: hold clr=1 for 2 clk with d=0, en=1 -> q=0x00, valid=0, perr=0, ferr=0, busy=0; still in IDLE after clr drops while d=1.
- Good frame, WIDTH=8, even parity, en=1: d sequence 0, 1,0,1,0,0,1,0,1, 0, 1 (data 0xA5, parity 0, stop 1) -> valid=1 for exactly 1 cycle after the stop edge, q=0xA5, perr=0, ferr=0, busy returns to 0.
- Parity error: same frame with parity bit 1 -> valid=1, q=0xA5, perr=1, ferr=0.
- Framing error: 0xA5 frame with stop bit 0, then d=0 for 3 more en edges, then d=1 -> ferr pulses once, valid=0, q keeps its previous value, busy stays 1 until d=1 is sampled, then IDLE.
- Strobe gating and back-to-back: en alternating 1/0, frame 0xA5 followed immediately by frame 0x3C (parity 0) -> two valid pulses 22 clk apart, q=0xA5 then q=0x3C, perr=0 both times.
- Reset mid-frame: assert clr for 1 cycle after the 4th data bit of 0xA5 -> next cycle busy=0, no valid/ferr pulse, q=0x00; a following clean 0x3C frame is received with valid=1, q=0x3C, perr=0.
